// File: rtl/binning_pkg.sv
// Shared widths and defaults for the 2D binner; BINNING_SUM_EN selects full-sum output width.
package binning_pkg;

  localparam int DW_DEF = 12;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_sh(input int bin_h, input int bin_v);
    return $clog2(bin_h * bin_v);
  endfunction

  function automatic int calc_ocols(input int line_w, input int bin_h);
    return line_w / bin_h;
  endfunction

  function automatic int calc_ow(input int dw, input int sh);
`ifdef BINNING_SUM_EN
    return dw + sh;
`else
    return dw;
`endif
  endfunction

endpackage

// File: rtl/binning_2d_if.sv
// Input raster stream plus binned output stream of the 2D binner.
interface binning_2d_if
  import binning_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = DW_DEF
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_sof;
  logic          s_last;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport slave (
    input  s_data, s_valid, s_sof, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, s_sof, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/binning_line_acc.sv
// Per-column partial-sum RAM: async read, sync write; sum is din or mem[addr]+din.
module binning_line_acc #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int W     = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  input  logic          add_sel,
  input  logic          wr_en,
  output logic [W-1:0]  sum
);
  logic [W-1:0] mem [DEPTH];

  assign sum = add_sel ? (mem[addr] + din) : din;

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= sum;
  end
endmodule

// File: rtl/binning_2d.sv
// BIN_H x BIN_V raster binner; output 1 cycle after last contributing sample, s_ready = ~m_valid | m_ready.
// Average (truncating) by default; `define BINNING_SUM_EN to emit the unshifted full-precision sum.
module binning_2d
  import binning_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int LINE_W = 640,
  parameter int BIN_H  = 2,
  parameter int BIN_V  = 2
) (
  input  logic          clk,
  input  logic          rst,
  binning_2d_if.slave   bus,
  output logic          line_err
);
  localparam int SH    = calc_sh(BIN_H, BIN_V);
  localparam int OCOLS = calc_ocols(LINE_W, BIN_H);
  localparam int AW    = DW + SH;
  localparam int OW    = calc_ow(DW, SH);
  localparam int HW    = cnt_w(BIN_H);
  localparam int CW    = cnt_w(OCOLS);
  localparam int VW    = cnt_w(BIN_V);

  logic [HW-1:0] hcnt, hc;
  logic [CW-1:0] col, cc;
  logic [VW-1:0] vcnt, vc, vnext;
  logic [AW-1:0] hsum, t, acc_sum;
  logic [OW-1:0] out_val;
  logic          xfer, bin_done, at_end, line_end, emit;

  assign bus.s_ready = ~bus.m_valid | bus.m_ready;
  assign xfer        = bus.s_valid & bus.s_ready;

  // A start-of-frame sample sees zeroed counters before it is processed
  assign hc = bus.s_sof ? '0 : hcnt;
  assign cc = bus.s_sof ? '0 : col;
  assign vc = bus.s_sof ? '0 : vcnt;

  assign t        = ((hc == '0) ? '0 : hsum) + AW'(bus.s_data);
  assign bin_done = xfer & (hc == HW'(BIN_H - 1));
  assign at_end   = bin_done & (cc == CW'(OCOLS - 1));
  assign line_end = xfer & (bus.s_last | at_end);
  assign emit     = bin_done & (vc == VW'(BIN_V - 1));
  assign vnext    = (vc == VW'(BIN_V - 1)) ? '0 : vc + VW'(1);

  binning_line_acc #(
    .DEPTH (OCOLS),
    .AW    (CW),
    .W     (AW)
  ) u_line_acc (
    .clk     (clk),
    .addr    (cc),
    .din     (t),
    .add_sel (vc != '0),
    .wr_en   (bin_done & ~emit),
    .sum     (acc_sum)
  );

`ifdef BINNING_SUM_EN
  assign out_val = acc_sum;
`else
  assign out_val = OW'(acc_sum >> SH);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      col         <= '0;
      vcnt        <= '0;
      hsum        <= '0;
      line_err    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
    end else begin
      if (xfer) begin
        hsum <= t;
        if (line_end) begin
          hcnt <= '0;
          col  <= '0;
          vcnt <= vnext;
        end else if (bin_done) begin
          hcnt <= '0;
          col  <= cc + CW'(1);
          vcnt <= vc;
        end else begin
          hcnt <= hc + HW'(1);
          col  <= cc;
          vcnt <= vc;
        end
        // Early s_last, or a full line with no s_last, both flag a bad line
        if (bus.s_last ^ at_end) line_err <= 1'b1;
      end
      if (emit) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= out_val;
        bus.m_last  <= (cc == CW'(OCOLS - 1));
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_binning_2d.sv
// Directed bench for binning_2d at LINE_W=8, 2x2 bins; expectations follow BINNING_SUM_EN.
module tb_binning_2d;
  import binning_pkg::*;

  localparam int DW     = 12;
  localparam int LINE_W = 8;
  localparam int BIN_H  = 2;
  localparam int BIN_V  = 2;
  localparam int SH     = calc_sh(BIN_H, BIN_V);
  localparam int OW     = calc_ow(DW, SH);
  localparam int BUDGET = 50;

`ifdef BINNING_SUM_EN
  localparam int E0 = 26, E1 = 34, E2 = 42, E3 = 50, EMAX = 16380;
`else
  localparam int E0 = 6, E1 = 8, E2 = 10, E3 = 12, EMAX = 4095;
`endif

  logic clk = 1'b0;
  logic rst;
  logic line_err;
  int   errors = 0;
  int   checks = 0;
  int   oq[$];
  logic lq[$];

  binning_2d_if #(.DW(DW), .OW(OW)) bif ();

  binning_2d #(
    .DW     (DW),
    .LINE_W (LINE_W),
    .BIN_H  (BIN_H),
    .BIN_V  (BIN_V)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif),
    .line_err (line_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bif.m_valid && bif.m_ready) begin
      oq.push_back(int'(bif.m_data));
      lq.push_back(bif.m_last);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_smp(input int d, input bit sof, input bit last);
    int n;
    n = 0;
    bif.s_data  = DW'(d);
    bif.s_sof   = sof;
    bif.s_last  = last;
    bif.s_valid = 1'b1;
    while (!bif.s_ready && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) begin
      errors++;
      checks++;
      $error("FAIL send_timeout: observed s_ready=0 for %0d cycles, expected acceptance", n);
    end
    step();
    bif.s_valid = 1'b0;
    bif.s_sof   = 1'b0;
    bif.s_last  = 1'b0;
  endtask

  task automatic send_line(input int first, input int inc, input int n, input bit sof, input bit last);
    for (int i = 0; i < n; i++)
      send_smp(first + i * inc, sof && (i == 0), last && (i == n - 1));
  endtask

  task automatic chk_out(input string tag, input int a, input int b, input int c, input int d);
    int e[4];
    e = '{a, b, c, d};
    chk({tag, "_count"}, oq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < oq.size()) begin
        chk($sformatf("%s_data%0d", tag, i), oq[i], e[i]);
        chk($sformatf("%s_last%0d", tag, i), lq[i], (i == 3) ? 1 : 0);
      end
    end
    oq.delete();
    lq.delete();
  endtask

  initial begin
    rst         = 1'b1;
    bif.s_data  = '0;
    bif.s_valid = 1'b0;
    bif.s_sof   = 1'b0;
    bif.s_last  = 1'b0;
    bif.m_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_m_valid", bif.m_valid, 0);
    chk("rst_m_data", bif.m_data, 0);
    chk("rst_m_last", bif.m_last, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_s_ready", bif.s_ready, 1);

    // basic 2x2 binning with latency check
    send_line(1, 1, 8, 1, 1);
    chk("s1_no_out_line0", oq.size(), 0);
    send_smp(11, 0, 0);
    chk("lat_pre", bif.m_valid, 0);
    send_smp(12, 0, 0);
    chk("lat_vld", bif.m_valid, 1);
    chk("lat_dat", bif.m_data, E0);
    send_line(13, 1, 6, 0, 1);
    step();
    chk_out("s1", E0, E1, E2, E3);
    chk("s1_line_err", line_err, 0);

    // full-scale samples
    send_line(4095, 0, 8, 1, 1);
    send_line(4095, 0, 8, 0, 1);
    step();
    chk_out("max", EMAX, EMAX, EMAX, EMAX);

    // output backpressure for 5 cycles
    send_line(1, 1, 8, 1, 1);
    fork
      send_line(11, 1, 8, 0, 1);
      begin
        int n;
        logic [31:0] held;
        n = 0;
        bif.m_ready = 1'b0;
        while (!bif.m_valid && n < BUDGET) begin
          step();
          n++;
        end
        held = 32'(bif.m_data);
        chk("bp_first", held, E0);
        repeat (5) begin
          chk("bp_s_ready", bif.s_ready, 0);
          chk("bp_hold", bif.m_data, held);
          step();
        end
        bif.m_ready = 1'b1;
      end
    join
    step();
    chk_out("bp", E0, E1, E2, E3);

    // sof after one line of a group restarts the vertical count
    send_line(100, 0, 8, 1, 1);
    chk("sof_none", oq.size(), 0);
    send_line(1, 1, 8, 1, 1);
    chk("sof_mid", oq.size(), 0);
    send_line(11, 1, 8, 0, 1);
    step();
    chk_out("sof", E0, E1, E2, E3);

    // early s_last
    send_line(1, 1, 6, 1, 1);
    chk("err_set", line_err, 1);
    chk("err_no_out", oq.size(), 0);
    send_line(1, 1, 8, 1, 1);
    send_line(11, 1, 8, 0, 1);
    step();
    chk_out("err", E0, E1, E2, E3);
    chk("err_sticky", line_err, 1);

    // reset mid-line with a pending output
    send_line(1, 1, 8, 1, 1);
    bif.m_ready = 1'b0;
    send_smp(11, 0, 0);
    send_smp(12, 0, 0);
    chk("rst_pre_vld", bif.m_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_m_valid", bif.m_valid, 0);
    chk("rst_mid_s_ready", bif.s_ready, 1);
    chk("rst_mid_line_err", line_err, 0);
    bif.m_ready = 1'b1;
    oq.delete();
    lq.delete();
    send_line(1, 1, 8, 0, 1);
    send_line(11, 1, 8, 0, 1);
    step();
    chk_out("rst", E0, E1, E2, E3);

    // full line without s_last is forced ended
    send_line(1, 1, 8, 1, 0);
    chk("force_err", line_err, 1);
    chk("force_no_out", oq.size(), 0);
    send_line(11, 1, 8, 0, 1);
    step();
    chk_out("force", E0, E1, E2, E3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
